// File: rtl/shiftadd_req_arbiter.sv
// Round-robin front end that shares one iterative shift-add modular reducer among NUM_REQ requesters.
// Latency: grant in cycle t, core start at t+1, response the cycle after core_valid_i (zero modulus responds at t+1).
// Backpressure: one operation in flight; requests hold req_i while busy_o is high and are granted only from IDLE.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_i / gnt_o             request levels in, one-hot single-cycle grant out (combinational in IDLE)
//   x_i, m_i, m_bl_i          packed per-requester operands, sampled in the grant cycle
//   valid_o, result_o, err_o  one-hot response strobe to the owner, registered result, error pulse
//   owner_o, busy_o           current/last owner index, high whenever not IDLE
//   core_*                    start pulse, captured operands, and result/valid back from the reducer core
module shiftadd_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_LENGTH    = 64,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] x_i,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] m_i,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] m_bl_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             valid_o,
    output logic [DATA_LENGTH-1:0]         result_o,
    output logic                           err_o,
    output logic [ID_W-1:0]                owner_o,
    output logic                           busy_o,
    output logic                           core_start_o,
    output logic [DATA_LENGTH-1:0]         core_x_o,
    output logic [DATA_LENGTH-1:0]         core_m_o,
    output logic [DATA_LENGTH-1:0]         core_m_bl_o,
    input  logic [DATA_LENGTH-1:0]         core_result_i,
    input  logic                           core_valid_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // One extra bit so TIMEOUT_CYCLES-1 always fits, including power-of-two values.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t                 state_q;
    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        owner_q;
    logic [DATA_LENGTH-1:0] x_q;
    logic [DATA_LENGTH-1:0] m_q;
    logic [DATA_LENGTH-1:0] m_bl_q;
    logic [DATA_LENGTH-1:0] result_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_REQ-1:0]     valid_q;
    logic                   err_q;
    logic                   start_q;

    // Arbitration result for the current cycle.
    logic                   sel_vld_d;
    logic [ID_W-1:0]        sel_d;
    logic [ID_W-1:0]        ptr_d;
    logic [NUM_REQ-1:0]     gnt_d;
    logic [DATA_LENGTH-1:0] sel_x_d;
    logic [DATA_LENGTH-1:0] sel_m_d;
    logic [DATA_LENGTH-1:0] sel_m_bl_d;
    logic [ID_W:0]          idx;

    // Scan upward from the pointer, wrapping modulo NUM_REQ; first set bit wins.
    always_comb begin
        sel_vld_d = 1'b0;
        sel_d     = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!sel_vld_d && req_i[idx[ID_W-1:0]]) begin
                sel_vld_d = 1'b1;
                sel_d     = idx[ID_W-1:0];
            end
        end

        sel_x_d    = x_i[int'(sel_d)*DATA_LENGTH +: DATA_LENGTH];
        sel_m_d    = m_i[int'(sel_d)*DATA_LENGTH +: DATA_LENGTH];
        sel_m_bl_d = m_bl_i[int'(sel_d)*DATA_LENGTH +: DATA_LENGTH];

        if (sel_d == ID_W'(NUM_REQ-1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = sel_d + 1'b1;
        end

        gnt_d = '0;
        if (state_q == IDLE && sel_vld_d) begin
            gnt_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            x_q      <= '0;
            m_q      <= '0;
            m_bl_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            valid_q  <= '0;
            err_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly the cycle of its state.
            valid_q <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_vld_d) begin
                        owner_q <= sel_d;
                        x_q     <= sel_x_d;
                        m_q     <= sel_m_d;
                        m_bl_q  <= sel_m_bl_d;
                        ptr_q   <= ptr_d;
                        if (sel_m_d == '0) begin
                            // The reducer would never terminate on a zero modulus: answer with an error directly.
                            result_q <= '0;
                            valid_q  <= gnt_d;
                            err_q    <= 1'b1;
                            state_q  <= RESP;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A completion on the timeout cycle still counts as a good result.
                    if (core_valid_i) begin
                        result_q <= core_result_i;
                        valid_q  <= NUM_REQ'(1) << owner_q;
                        state_q  <= RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
                        result_q <= '0;
                        valid_q  <= NUM_REQ'(1) << owner_q;
                        err_q    <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o        = gnt_d;
    assign valid_o      = valid_q;
    assign result_o     = result_q;
    assign err_o        = err_q;
    assign owner_o      = owner_q;
    assign busy_o       = (state_q != IDLE);
    assign core_start_o = start_q;
    assign core_x_o     = x_q;
    assign core_m_o     = m_q;
    assign core_m_bl_o  = m_bl_q;

endmodule

// File: tb/tb_shiftadd_req_arbiter.sv
// Self-checking bench for shiftadd_req_arbiter with a behavioural reducer core.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_shiftadd_req_arbiter;

    localparam int N  = 4;
    localparam int DL = 64;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_i;
    logic [N*DL-1:0] x_i, m_i, m_bl_i;
    logic [N-1:0]    gnt_o, valid_o;
    logic [DL-1:0]   result_o;
    logic            err_o;
    logic [1:0]      owner_o;
    logic            busy_o, core_start_o;
    logic [DL-1:0]   core_x_o, core_m_o, core_m_bl_o;
    logic [DL-1:0]   core_result_i;
    logic            core_valid_i;

    always #5 clk = ~clk;

    shiftadd_req_arbiter #(
        .NUM_REQ(N), .DATA_LENGTH(DL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i),
        .x_i(x_i), .m_i(m_i), .m_bl_i(m_bl_i),
        .gnt_o(gnt_o), .valid_o(valid_o), .result_o(result_o), .err_o(err_o),
        .owner_o(owner_o), .busy_o(busy_o), .core_start_o(core_start_o),
        .core_x_o(core_x_o), .core_m_o(core_m_o), .core_m_bl_o(core_m_bl_o),
        .core_result_i(core_result_i), .core_valid_i(core_valid_i)
    );

    // Per-requester operands and the response each one should receive.
    logic [DL-1:0] x_a [N];
    logic [DL-1:0] m_a [N];
    logic [DL-1:0] bl_a[N];
    logic [DL-1:0] exp_res_a[N];
    logic          exp_err_a[N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            x_i[i*DL +: DL]    = x_a[i];
            m_i[i*DL +: DL]    = m_a[i];
            m_bl_i[i*DL +: DL] = bl_a[i];
        end
    end

    typedef struct {
        int            owner;
        logic [DL-1:0] result;
        logic          err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int            idx;
        logic [DL-1:0] x;
        logic [DL-1:0] m;
        logic [DL-1:0] bl;
        int            lat;
        bit            hang;
        logic [DL-1:0] exp_res;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    int n_gnt = 0, gnt_idx = -1, gnt_cyc = 0;
    int n_valid = 0, valid_cyc = 0;
    int n_start = 0, start_cyc = 0;
    logic [DL-1:0] start_x, start_bl;

    // Behavioural core state.
    int            core_lat  = 1;
    bit            core_hang = 1'b0;
    int            core_cnt  = 0;
    logic [DL-1:0] cx, cm;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Observes outputs mid-cycle; grants push expectations, responses pop and compare.
    task automatic monitor();
        exp_t e;
        if (gnt_o != '0) begin
            chk("gnt_onehot", 64'($onehot(gnt_o)), 64'd1);
            n_gnt++;
            gnt_cyc = cyc_n;
            for (int i = 0; i < N; i++) if (gnt_o[i]) gnt_idx = i;
            e.owner  = gnt_idx;
            e.result = exp_res_a[gnt_idx];
            e.err    = exp_err_a[gnt_idx];
            sb.push_back(e);
        end
        if (core_start_o) begin
            n_start++;
            start_cyc = cyc_n;
            start_x   = core_x_o;
            start_bl  = core_m_bl_o;
        end
        if (valid_o != '0) begin
            n_valid++;
            valid_cyc = cyc_n;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'(valid_o), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_valid_vec", 64'(valid_o), 64'(1) << e.owner);
                chk("resp_result", result_o, e.result);
                chk("resp_err", 64'(err_o), 64'(e.err));
                chk("resp_owner", 64'(owner_o), 64'(e.owner));
            end
        end else if (err_o) begin
            chk("err_without_valid", 64'(err_o), 64'd0);
        end
    endtask

    task automatic core_model();
        core_valid_i  = 1'b0;
        core_result_i = '0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_valid_i  = 1'b1;
                core_result_i = cx % cm;
            end
        end
        if (core_start_o && !core_hang) begin
            core_cnt = core_lat;
            cx       = core_x_o;
            cm       = core_m_o;
        end
    endtask

    // One clock: check outputs at the falling edge, then step the core just after the rising edge.
    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc_n++;
        core_model();
    endtask

    task automatic do_reset();
        rst_i    = 1'b1;
        sb.delete();
        core_cnt = 0;
        repeat (2) cyc();
        rst_i = 1'b0;
    endtask

    vec_t vecs[7];
    int   exp_order[5];
    int   order[5];
    int   g0, v0, s0, got, prev;

    initial begin
        rst_i        = 1'b1;
        req_i        = '0;
        core_valid_i = 1'b0;
        core_result_i = '0;
        for (int i = 0; i < N; i++) begin
            x_a[i] = '0; m_a[i] = '0; bl_a[i] = '0;
            exp_res_a[i] = '0; exp_err_a[i] = 1'b0;
        end

        //           idx  x                       m    bl lat hang exp_res err lat
        vecs[0] = '{2, 64'd100,                64'd7,  64'd3, 4,  1'b0, 64'd2,  1'b0, 6};
        vecs[1] = '{1, 64'd55,                 64'd0,  64'd0, 1,  1'b0, 64'd0,  1'b1, 1};
        vecs[2] = '{0, 64'd77,                 64'd9,  64'd4, 1,  1'b1, 64'd0,  1'b1, 18};
        vecs[3] = '{3, 64'd12345,              64'd97, 64'd7, 1,  1'b0, 64'd26, 1'b0, 3};
        vecs[4] = '{2, 64'd1000,               64'd37, 64'd6, 16, 1'b0, 64'd1,  1'b0, 18};
        vecs[5] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd4, 2,  1'b0, 64'd5,  1'b0, 4};
        vecs[6] = '{0, 64'd5,                  64'd11, 64'd4, 15, 1'b0, 64'd5,  1'b0, 17};

        repeat (3) cyc();
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_owner", 64'(owner_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_start", 64'(core_start_o), 64'd0);
        chk("rst_core_x", core_x_o, 64'd0);
        chk("rst_core_m", core_m_o, 64'd0);
        rst_i = 1'b0;
        cyc();

        // Single-requester vectors: latency, results, zero modulus, timeout and timeout-coincident completion.
        for (int v = 0; v < 7; v++) begin
            core_lat  = vecs[v].lat;
            core_hang = vecs[v].hang;
            x_a[vecs[v].idx]       = vecs[v].x;
            m_a[vecs[v].idx]       = vecs[v].m;
            bl_a[vecs[v].idx]      = vecs[v].bl;
            exp_res_a[vecs[v].idx] = vecs[v].exp_res;
            exp_err_a[vecs[v].idx] = vecs[v].exp_err;
            g0 = n_gnt; s0 = n_start; v0 = n_valid;
            req_i[vecs[v].idx] = 1'b1;
            for (int k = 0; k < 20 && n_gnt == g0; k++) cyc();
            chk($sformatf("v%0d_gnt_seen", v), 64'(n_gnt - g0), 64'd1);
            chk($sformatf("v%0d_gnt_idx", v), 64'(gnt_idx), 64'(vecs[v].idx));
            req_i = '0;
            for (int k = 0; k < 60 && n_valid == v0; k++) cyc();
            chk($sformatf("v%0d_valid_seen", v), 64'(n_valid - v0), 64'd1);
            chk($sformatf("v%0d_latency", v), 64'(valid_cyc - gnt_cyc), 64'(vecs[v].exp_lat));
            if (vecs[v].m == '0) begin
                chk($sformatf("v%0d_no_start", v), 64'(n_start - s0), 64'd0);
            end else begin
                chk($sformatf("v%0d_start_cnt", v), 64'(n_start - s0), 64'd1);
                chk($sformatf("v%0d_start_lat", v), 64'(start_cyc - gnt_cyc), 64'd1);
                chk($sformatf("v%0d_core_x", v), start_x, vecs[v].x);
                chk($sformatf("v%0d_core_m_bl", v), start_bl, vecs[v].bl);
            end
            repeat (2) cyc();
        end

        // All four requesting continuously from reset: grant order 0,1,2,3,0.
        do_reset();
        core_hang = 1'b0;
        core_lat  = 3;
        for (int i = 0; i < N; i++) begin
            x_a[i]       = 64'(1000 + 37 * i);
            m_a[i]       = 64'd13;
            bl_a[i]      = 64'd4;
            exp_res_a[i] = x_a[i] % 64'd13;
            exp_err_a[i] = 1'b0;
        end
        exp_order = '{0, 1, 2, 3, 0};
        v0 = n_valid; got = 0; prev = n_gnt;
        req_i = 4'b1111;
        for (int k = 0; k < 200 && got < 5; k++) begin
            cyc();
            if (n_gnt != prev) begin
                order[got] = gnt_idx;
                got++;
                prev = n_gnt;
            end
        end
        req_i = '0;
        for (int k = 0; k < 40 && (sb.size() != 0 || busy_o); k++) cyc();
        chk("rr_grants", 64'(got), 64'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order_%0d", i), 64'(order[i]), 64'(exp_order[i]));
        chk("rr_responses", 64'(n_valid - v0), 64'd5);

        // Reset during WAIT, then a stale completion: no response, pointer back to 0.
        core_hang    = 1'b1;
        x_a[1]       = 64'd40; m_a[1] = 64'd6;
        exp_res_a[1] = 64'd0;  exp_err_a[1] = 1'b1;
        g0 = n_gnt;
        req_i = 4'b0010;
        for (int k = 0; k < 20 && n_gnt == g0; k++) cyc();
        chk("rw_gnt_idx", 64'(gnt_idx), 64'd1);
        req_i = '0;
        repeat (4) cyc();
        chk("rw_busy_before", 64'(busy_o), 64'd1);
        rst_i    = 1'b1;
        sb.delete();
        core_cnt = 0;
        cyc();
        rst_i         = 1'b0;
        core_valid_i  = 1'b1;
        core_result_i = 64'h55;
        chk("rw_busy_after", 64'(busy_o), 64'd0);
        chk("rw_owner_after", 64'(owner_o), 64'd0);
        chk("rw_result_after", result_o, 64'd0);
        v0 = n_valid;
        repeat (4) cyc();
        chk("rw_no_valid", 64'(n_valid - v0), 64'd0);
        chk("rw_still_idle", 64'(busy_o), 64'd0);
        core_hang = 1'b0;
        core_lat  = 2;
        x_a[1] = 64'd40; m_a[1] = 64'd6; exp_res_a[1] = 64'd4; exp_err_a[1] = 1'b0;
        x_a[2] = 64'd50; m_a[2] = 64'd7; exp_res_a[2] = 64'd1; exp_err_a[2] = 1'b0;
        g0 = n_gnt; v0 = n_valid;
        req_i = 4'b0110;
        for (int k = 0; k < 20 && n_gnt == g0; k++) cyc();
        chk("rw_next_gnt_idx", 64'(gnt_idx), 64'd1);
        req_i = '0;
        for (int k = 0; k < 40 && n_valid == v0; k++) cyc();
        chk("rw_next_valid", 64'(n_valid - v0), 64'd1);

        repeat (3) cyc();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
